// File: rtl/bram_stream_loader_pkg.sv
// Shared constants and FSM encoding for the BRAM stream loader and its data-request sibling.
package bram_stream_loader_pkg;

    localparam int unsigned NUM_BYTE       = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_REG_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bram_stream_loader.sv
// Streams host words into a BRAM write port, one registered write per accepted beat.
// Define LOADER_CHECKSUM_EN to accumulate an additive checksum of the written words.
module bram_stream_loader
    import bram_stream_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
    parameter int unsigned ADDR_STEP  = NUM_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [REG_WIDTH-1:0]  i_num_words,
    input  logic [DATA_WIDTH-1:0] s_dat,
    input  logic                  s_val,
    input  logic                  s_last,
    output logic                  s_rdy,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_wren,
    output logic [DATA_WIDTH-1:0] o_idat,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  o_count,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [REG_WIDTH-1:0]  num_q;
    logic                  accept;
    logic                  beat;
    logic                  final_beat;
    logic                  frame_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; abort wins and masks the beat in its cycle
    always_comb begin
        state_nxt  = state;
        s_rdy      = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        accept     = 1'b0;
        beat       = 1'b0;
        final_beat = 1'b0;
        frame_err  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = (i_num_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    s_rdy = 1'b1;
                    beat  = s_val;
                    if (s_val) begin
                        final_beat = (o_count == num_q - REG_WIDTH'(1));
                        // s_last must land exactly on the final word; either mismatch is a framing error
                        frame_err  = final_beat ^ s_last;
                        if (final_beat || s_last) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write stage, word index and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            next_addr <= '0;
            o_count   <= '0;
            o_addr    <= '0;
            o_idat    <= '0;
            o_wren    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_wren <= beat;
            if (accept) begin
                num_q     <= i_num_words;
                next_addr <= i_base_addr;
                o_count   <= '0;
                o_err     <= 1'b0;
            end
            if (beat) begin
                o_addr    <= next_addr;
                o_idat    <= s_dat;
                next_addr <= next_addr + ADDR_WIDTH'(ADDR_STEP);
                o_count   <= o_count + REG_WIDTH'(1);
            end
            if (frame_err) begin
                o_err <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum moves in step with o_wren and holds after completion
    always_ff @(posedge clk) begin
        if (rst) begin
            o_checksum <= '0;
        end else if (accept) begin
            o_checksum <= '0;
        end else if (beat) begin
            o_checksum <= o_checksum + s_dat;
        end
    end
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Scoreboard bench for bram_stream_loader: directed plan cases plus randomized transfers.
`timescale 1ns/1ps
module tb_bram_stream_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          count;
        bit          err;
        logic [31:0] sum;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [31:0] i_num_words = '0;
    logic [31:0] s_dat = '0;
    logic        s_val = 1'b0;
    logic        s_last = 1'b0;
    logic        s_rdy;
    logic [31:0] o_addr;
    logic        o_wren;
    logic [31:0] o_idat;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_count;
    logic [31:0] o_checksum;

    logic        exp_wren = 1'b0;
    wr_t         exp_wr[$];
    done_t       exp_done[$];
    int          vectors = 0;
    int          miscompares = 0;

    bram_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_base_addr(i_base_addr),
        .i_num_words(i_num_words),
        .s_dat      (s_dat),
        .s_val      (s_val),
        .s_last     (s_last),
        .s_rdy      (s_rdy),
        .o_addr     (o_addr),
        .o_wren     (o_wren),
        .o_idat     (o_idat),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_count    (o_count),
        .o_checksum (o_checksum)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void flag_fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // A write must follow every accepted beat by exactly one cycle
    always @(posedge clk) exp_wren <= !rst && s_val && s_rdy;

    // Monitor: pops expected writes and completions as the DUT presents them
    always @(negedge clk) begin
        if (o_wren || exp_wren) check("wren_timing", 64'(o_wren), 64'(exp_wren));
        if (o_wren) begin
            if (exp_wr.size() == 0) begin
                flag_fail("unexpected_write");
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", 64'(o_addr), 64'(w.addr));
                check("wr_data", 64'(o_idat), 64'(w.data));
            end
        end
        if (o_done) begin
            if (exp_done.size() == 0) begin
                flag_fail("unexpected_done");
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_count", 64'(o_count), 64'(d.count));
                check("done_err", 64'(o_err), 64'(d.err));
                check("done_checksum", 64'(o_checksum), 64'(d.sum));
                check("done_writes_drained", 64'(exp_wr.size()), 64'(0));
                check("done_with_last_wren", 64'(o_wren), 64'(d.count != 0));
            end
        end
    end

    function automatic logic [31:0] csum_of(logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return (s & 32'h0);
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // last_pos < 0 means no s_last; abort_after < 0 means no abort; val_pct < 0 toggles s_val.
    task automatic run_xfer(input logic [31:0] base, input int num, input int last_pos,
                            input int abort_after, input int val_pct, input bit fixed_words);
        logic [31:0] words[$];
        logic [31:0] sum;
        logic [31:0] w;
        int          n_full;
        int          n_written;
        bit          aborted;
        bit          exp_err;
        int          beats;
        int          budget;
        int          cyc;

        n_full    = (last_pos >= 0 && last_pos < num) ? last_pos + 1 : num;
        aborted   = (abort_after >= 0 && abort_after < n_full);
        n_written = aborted ? abort_after : n_full;
        exp_err   = (!aborted && num > 0 && last_pos != num - 1);
        sum       = '0;
        for (int i = 0; i < n_written; i++) begin
            w = fixed_words ? 32'hA0 + 32'(i) : $urandom;
            words.push_back(w);
            sum = sum + w;
            exp_wr.push_back('{addr: base + 32'(4 * i), data: w});
        end
        if (!aborted) exp_done.push_back('{count: n_written, err: exp_err, sum: csum_of(sum)});

        // Abort alongside start in IDLE must be ignored
        i_start     = 1'b1;
        i_base_addr = base;
        i_num_words = 32'(num);
        i_abort     = 1'($urandom_range(1));
        #1 check("idle_s_rdy", 64'(s_rdy), 64'(0));
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;

        beats  = 0;
        budget = 0;
        cyc    = 0;
        if (num > 0) begin
            forever begin
                if (beats == n_written && aborted) begin
                    s_val   = 1'b1;
                    s_dat   = $urandom;
                    s_last  = 1'b0;
                    i_abort = 1'b1;
                    #1 check("abort_s_rdy", 64'(s_rdy), 64'(0));
                    @(negedge clk);
                    break;
                end
                if (beats == n_written) break;
                s_dat       = words[beats];
                s_last      = (beats == last_pos);
                s_val       = (val_pct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < val_pct);
                i_start     = ($urandom_range(7) == 0);
                i_base_addr = $urandom;
                i_num_words = $urandom;
                #1 check("load_s_rdy", 64'(s_rdy), 64'(1));
                check("load_busy", 64'(o_busy), 64'(1));
                if (s_val && s_rdy) beats++;
                @(negedge clk);
                cyc++;
                budget++;
                if (budget > 2000) begin
                    flag_fail("beat_timeout");
                    break;
                end
            end
        end
        s_val   = 1'b0;
        s_last  = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        if (!aborted) begin
            check("done_s_rdy", 64'(s_rdy), 64'(0));
            @(negedge clk);
        end
        check("end_s_rdy", 64'(s_rdy), 64'(0));
        check("end_busy", 64'(o_busy), 64'(0));
        check("end_count", 64'(o_count), 64'(n_written));
        check("end_err", 64'(o_err), 64'(exp_err));
        check("end_checksum", 64'(o_checksum), 64'(csum_of(sum)));
        @(negedge clk);
        check("idle_no_done", 64'(o_done), 64'(0));
        exp_wr.delete();
        exp_done.delete();
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_wren"}, 64'(o_wren), 64'(0));
        check({tag, "_addr"}, 64'(o_addr), 64'(0));
        check({tag, "_idat"}, 64'(o_idat), 64'(0));
        check({tag, "_count"}, 64'(o_count), 64'(0));
        check({tag, "_err"}, 64'(o_err), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_s_rdy"}, 64'(s_rdy), 64'(0));
        check({tag, "_checksum"}, 64'(o_checksum), 64'(0));
    endtask

    task automatic reset_mid_load();
        logic [31:0] w0;
        w0          = $urandom;
        i_start     = 1'b1;
        i_base_addr = 32'h200;
        i_num_words = 32'd5;
        @(negedge clk);
        i_start = 1'b0;
        s_val   = 1'b1;
        s_last  = 1'b0;
        s_dat   = w0;
        exp_wr.push_back('{addr: 32'h200, data: w0});
        @(negedge clk);
        s_dat = $urandom;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        s_val = 1'b0;
        check_reset_values("midrst");
        check("midrst_drained", 64'(exp_wr.size()), 64'(0));
        exp_wr.delete();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int num;
        int last_pos;
        int abort_after;
        int sel;
        logic [31:0] base;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        run_xfer(32'h100, 4, 3, -1, 100, 1'b1);
        run_xfer(32'h100, 4, 3, -1, -1, 1'b1);
        run_xfer(32'h100, 4, 1, -1, 100, 1'b0);
        run_xfer(32'h300, 3, 2, 1, 100, 1'b0);
        run_xfer(32'h400, 0, -1, -1, 100, 1'b0);
        run_xfer(32'hFFFF_FFFC, 2, 1, -1, 100, 1'b0);
        run_xfer(32'h500, 3, -1, -1, 70, 1'b0);
        reset_mid_load();

        for (int t = 0; t < 40; t++) begin
            num = $urandom_range(12);
            sel = $urandom_range(3);
            case (sel)
                0:       last_pos = num - 1;
                1:       last_pos = (num > 0) ? $urandom_range(num - 1) : -1;
                2:       last_pos = -1;
                default: last_pos = num + 2;
            endcase
            abort_after = ($urandom_range(3) == 0) ? $urandom_range(num) : -1;
            base = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3)) : $urandom;
            run_xfer(base, num, last_pos, abort_after, $urandom_range(100, 30), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
